uart_loader: RTL

- Upstream feeder for the instruction memory and the data memory during a program upload.
- Collects the UART receiver's byte stream into ISA-width little-endian words and drives the memory-side write interface (write enable, word address, data).
- Address bit ROM_DEPTH selects the target memory: 0 = instruction memory, 1 = data memory.
- Signals completion so the hazard unit can release the pipeline and issue pc_reset.

---
 rtl/uart_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// uart_loader: packs the UART receiver byte stream into little-endian
// ISA-width words and writes them to instruction memory (addr MSB = 0) or
// data memory (addr MSB = 1) during a program upload.
//
// Ports:
//   clk               system clock, all logic on posedge
//   rst               synchronous active-high reset
//   uart_start        pulse from hazard unit requesting a new upload
//   rx_valid/rx_data  one received byte per cycle at most
//   uart_write_enable one-cycle memory write strobe
//   uart_addr         word address of the current write (ROM_DEPTH+1 bits)
//   uart_data         assembled word
//   uart_busy         high from leaving IDLE until DONE is left
//   uart_done         one-cycle completion pulse
//   uart_error        sticky: upload ended on a partial word
module uart_loader #(
  parameter int ISA_WIDTH      = 32,
  parameter int ROM_DEPTH      = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 uart_write_enable,
  output logic [ROM_DEPTH:0]   uart_addr,
  output logic [ISA_WIDTH-1:0] uart_data,
  output logic                 uart_busy,
  output logic                 uart_done,
  output logic                 uart_error
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROM_DEPTH:0] ADDR_LAST = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state;
  logic [1:0]           idx;
  logic [ROM_DEPTH:0]   addr;
  logic [TMO_W-1:0]     tmo;
  logic [ISA_WIDTH-1:0] word;
  logic                 err;

  // Idle counter never wraps; it holds at its maximum.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    logic [TMO_W-1:0] r;
    r = (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= 2'd0;
      addr  <= '0;
      tmo   <= '0;
      word  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (uart_start) begin
            state <= S_RECV;
            idx   <= 2'd0;
            addr  <= '0;
            tmo   <= '0;
            err   <= 1'b0;
          end
        end
        S_RECV: begin
          if (rx_valid) begin
            word[{idx, 3'b000} +: 8] <= rx_data;
            idx <= idx + 2'd1;
            tmo <= '0;
            if (idx == 2'd3) state <= S_WRITE;
          end else if (tmo == TMO_LAST) begin
            // A partial word is dropped, never written.
            state <= S_DONE;
            if (idx != 2'd0) err <= 1'b1;
          end else begin
            tmo <= sat_inc(tmo);
          end
        end
        S_WRITE: begin
          // Address and data are held through the strobe cycle; a byte
          // arriving now becomes lane 0 of the next word.
          if (addr == ADDR_LAST) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_RECV;
            if (rx_valid) begin
              word[7:0] <= rx_data;
              idx       <= 2'd1;
              tmo       <= '0;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign uart_write_enable = (state == S_WRITE);
  assign uart_done         = (state == S_DONE);
  assign uart_busy         = (state != S_IDLE);
  assign uart_addr         = addr;
  assign uart_data         = word;
  assign uart_error        = err;

endmodule
